// File: rtl/fpe.sv
// Floating-point exponent and shift-sequencing unit: holds two signed exponents,
// computes align/mul/div exponents and sequences mantissa shift strobes.
module fpe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 40,
  parameter int CNT_W  = 6
) (
  input  logic             __clk,
  input  logic             _0_f,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [2:0]       cmd,
  input  logic             mant_norm,
  input  logic             mant_zero,
  input  logic             mant_ovf,
  output logic             shr,
  output logic             shl,
  output logic             swap,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] exp_r,
  output logic             g,
  output logic             ovf,
  output logic             unf,
  output logic             zr
);

  localparam int WW = EXP_W + 2;
  localparam logic signed [WW-1:0] EMAX     = WW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [WW-1:0] EMIN     = ~EMAX;
  localparam logic signed [WW-1:0] MANT_LIM = WW'(MANT_W);
  localparam logic [CNT_W-1:0]     CNT_LIM  = CNT_W'(MANT_W);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_SHIFT_R, S_NORM, S_CALC, S_RANGE, S_DONE
  } state_t;

  state_t             state;
  logic [EXP_W-1:0]   a_q, b_q;
  logic signed [WW-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               first;

  logic signed [WW-1:0] a_w, b_w, sum_w, dif_w, mag, acc_p1, acc_m1, exp_w;

  always_comb begin
    a_w    = {{2{a_q[EXP_W-1]}}, a_q};
    b_w    = {{2{b_q[EXP_W-1]}}, b_q};
    sum_w  = a_w + b_w;
    dif_w  = a_w - b_w;
    mag    = acc[WW-1] ? -acc : acc;
    acc_p1 = acc + WW'(1);
    acc_m1 = acc - WW'(1);
    exp_w  = {{2{exp_r[EXP_W-1]}}, exp_r};
  end

  always_ff @(posedge __clk or posedge _0_f) begin
    if (_0_f) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b0;
      shr   <= 1'b0;
      shl   <= 1'b0;
      swap  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      exp_r <= '0;
      g     <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      zr    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (ld_a) a_q <= exp_a;
          if (ld_b) b_q <= exp_b;
          // Operands are captured from the pre-load A/B on the accepting edge.
          if (cmd inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
            busy <= 1'b1;
            g    <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            zr   <= 1'b0;
            swap <= 1'b0;
          end
          unique case (cmd)
            3'd1: begin
              acc   <= dif_w;
              exp_r <= dif_w[WW-1] ? b_q : a_q;
              state <= S_ALIGN;
            end
            3'd2: begin
              acc   <= exp_w;
              cnt   <= '0;
              first <= 1'b1;
              state <= S_NORM;
            end
            3'd3: begin
              acc   <= sum_w;
              state <= S_CALC;
            end
            3'd4: begin
              acc   <= dif_w;
              state <= S_CALC;
            end
            default: state <= S_IDLE;
          endcase
        end

        S_ALIGN: begin
          swap <= acc[WW-1];
          if (mag >= MANT_LIM) begin
            g     <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (acc == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            shr   <= 1'b1;
            cnt   <= CNT_W'(mag);
            state <= S_SHIFT_R;
          end
        end

        S_SHIFT_R: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            shr   <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_NORM: begin
          first <= 1'b0;
          shr   <= 1'b0;
          shl   <= 1'b0;
          if (mant_zero) begin
            acc   <= '0;
            exp_r <= '0;
            zr    <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (first && mant_ovf) begin
            shr   <= 1'b1;
            acc   <= acc_p1;
            exp_r <= acc_p1[EXP_W-1:0];
          end else if (!mant_norm) begin
            // Give up once the full mantissa width has been shifted in.
            if (cnt == CNT_LIM) begin
              acc   <= '0;
              exp_r <= '0;
              zr    <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              shl   <= 1'b1;
              cnt   <= cnt + CNT_ONE;
              acc   <= acc_m1;
              exp_r <= acc_m1[EXP_W-1:0];
            end
          end else begin
            state <= S_RANGE;
          end
        end

        S_CALC: begin
          exp_r <= acc[EXP_W-1:0];
          state <= S_RANGE;
        end

        S_RANGE: begin
          if (acc > EMAX) begin
            ovf   <= 1'b1;
            exp_r <= EMAX[EXP_W-1:0];
          end else if (acc < EMIN) begin
            unf   <= 1'b1;
            zr    <= 1'b1;
            exp_r <= '0;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpe.md
# fpe

Parametrised floating-point exponent and shift-sequencing unit, the next-generation F-PM exponent path. It holds two signed exponents and performs the exponent arithmetic for add/sub alignment, mul and div. It sequences right/left shift strobes to the mantissa datapath for alignment and normalisation. It sits between the FP microprogram sequencer (commands, done) and the mantissa shift registers (shift strobes, status).

## Interface
- EXP_W, 8, exponent width, signed two's complement
- MANT_W, 40, mantissa width in bits; alignment swamp threshold and normalisation shift limit
- CNT_W, 6, shift counter width, must satisfy 2^CNT_W > MANT_W
---
- __clk  in  1  single clock; all state changes on rising edge
- _0_f  in  1  asynchronous, active-high reset
- ld_a / ld_b  in  1  load exp_a / exp_b into A / B when idle
- exp_a, exp_b  in  EXP_W  exponent operands
- cmd  in  3  0 none, 1 align, 2 norm, 3 mul, 4 div; sampled only when idle; 5..7 ignored
- mant_norm  in  1  mantissa normalised (sign bit differs from next bit)
- mant_zero  in  1  mantissa is zero
- mant_ovf  in  1  add produced carry into sign (needs one right shift)
- shr, shl  out  1  one-cycle shift strobes to mantissa path
- swap  out  1  align: B exponent larger, shr targets operand A
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- exp_r  out  EXP_W  result exponent
- g, ovf, unf, zr  out  1  swamp, exponent overflow, underflow, zero-result flags

## Operation
- Reset: A, B, exp_r, counter = 0; state IDLE; all outputs 0.
- Exponent arithmetic uses EXP_W+2 bits, sign-extended; range is Emin = -2^(EXP_W-1), Emax = 2^(EXP_W-1)-1.
- IDLE: ld_a/ld_b load A/B on the same edge. A cmd accepted in the same cycle as a load uses the old A/B.
- Cmd acceptance clears g, ovf, unf, zr and raises busy on the next edge. Loads and cmds are ignored while busy.
- ALIGN: diff = A - B, swap = diff < 0, exp_r = max(A, B).
  - If |diff| >= MANT_W: g = 1, no strobes, go to DONE.
  - If diff = 0: go to DONE immediately.
  - Otherwise counter = |diff|; SHIFT_R issues shr every cycle, counter decrements, until counter = 0, then DONE.
- NORM: exp_r is the working exponent, counter = 0. Status inputs are evaluated each NORM cycle, in priority order:
  - mant_zero: exp_r = 0, zr = 1, DONE; no range check.
  - mant_ovf: shr pulse, exp_r + 1. Only honoured on the first NORM cycle; ignored afterwards.
  - !mant_norm: shl pulse, exp_r - 1, counter + 1. If counter reaches MANT_W: zr = 1, exp_r = 0, DONE.
  - mant_norm: go to RANGE.
- MUL: exp_r = A + B. DIV: exp_r = A - B. Both take one cycle in CALC, then RANGE.
- RANGE: the wide result is checked.
  - Above Emax: ovf = 1, exp_r = Emax.
  - Below Emin: unf = 1, exp_r = 0, zr = 1.
  - Then DONE.
- DONE: done = 1 for one cycle, busy drops, return to IDLE. Flags and exp_r hold until the next accepted cmd.
- Reset mid-operation aborts immediately. No strobe is issued after reset assertion.

## Timing
- All outputs are registered. shr/shl/done never assert in the same cycle as each other.
- The mantissa path shifts on the same edge that ends the strobe cycle. Status inputs must be valid in the following cycle.
- ALIGN latency, from cmd edge to done: |diff| + 2 cycles; swamped or zero-diff case: 2 cycles.
- NORM latency: k left shifts + 3 cycles, where k = shifts performed; one extra cycle if mant_ovf.
- MUL/DIV latency: 3 cycles.
- busy is high from the edge after acceptance through the done cycle, inclusive.

## Test plan
- Reset, then check all outputs 0. Load A=5, B=2, cmd=align -> swap=0, exp_r=5, exactly 3 shr pulses on consecutive cycles, done 5 cycles after cmd.
- A=-3, B=60, align, MANT_W=40 -> g=1, swap=1, exp_r=60, no shr, done after 2 cycles.
- norm with exp_r=10, mant_norm rising after 4 shl -> exp_r=6, 4 shl pulses, ovf=unf=zr=0.
- norm, first cycle mant_ovf=1 and exp_r=127 -> one shr, ovf=1, exp_r=127.
- A=100, B=100, mul -> ovf=1, exp_r=127. A=-100, B=100, div -> unf=1, zr=1, exp_r=0.
- Assert _0_f during align with 10 pending shifts -> shr and busy drop immediately, no done. A cmd issued while busy is ignored.
